// File: rtl/if_layer_weight_loader.sv
// Weight-memory initiator for a spiking layer: LOAD streams a neuron-major
// weight image into the layer, VERIFY reads it back and counts mismatches.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   start, mode       one-cycle start pulse; mode 0 = LOAD, 1 = VERIFY
//   s_valid/s_ready   weight stream handshake, s_data = weight word
//   mem_addr/din/wen  layer memory write/read address and write data
//   mem_dout          layer memory read data (READ_LATENCY cycles behind)
//   busy, done        operation in flight / one-cycle completion pulse
//   mismatch_count    saturating VERIFY mismatch count
//   first_err_*       address of the first VERIFY mismatch
module if_layer_weight_loader #(
  parameter int WEIGHT_SIZE       = 32,
  parameter int NUM_INPUTS        = 4,
  parameter int NUM_NEURONS       = 1,
  parameter int LAYER_ADDR_WIDTH  = 28,
  parameter int WEIGHT_ADDR_WIDTH = 10,
  parameter int READ_LATENCY      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        mode,
  input  logic                        s_valid,
  input  logic [WEIGHT_SIZE-1:0]      s_data,
  output logic                        s_ready,
  output logic [LAYER_ADDR_WIDTH-1:0] mem_addr,
  output logic [WEIGHT_SIZE-1:0]      mem_din,
  output logic                        mem_wen,
  input  logic [WEIGHT_SIZE-1:0]      mem_dout,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 mismatch_count,
  output logic                        first_err_valid,
  output logic [LAYER_ADDR_WIDTH-1:0] first_err_addr
);

  localparam int WAW = WEIGHT_ADDR_WIDTH;
  localparam int NAW = LAYER_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;

  localparam logic [WAW-1:0] W_LAST = WAW'(NUM_INPUTS - 1);
  localparam logic [NAW-1:0] N_LAST = NAW'(NUM_NEURONS - 1);
  localparam logic [2:0]     LAT    = 3'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_COMPARE  = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [NAW-1:0]              n_q, n_d;
  logic [WAW-1:0]              w_q, w_d;
  logic [2:0]                  lat_q, lat_d;
  logic [WEIGHT_SIZE-1:0]      cap_q, cap_d;
  logic                        s_ready_q, s_ready_d;
  logic [LAYER_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WEIGHT_SIZE-1:0]      mem_din_q, mem_din_d;
  logic                        mem_wen_q, mem_wen_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [15:0]                 mm_q, mm_d;
  logic                        fev_q, fev_d;
  logic [LAYER_ADDR_WIDTH-1:0] fea_q, fea_d;

  logic                        hs;
  logic                        last_word;
  logic [LAYER_ADDR_WIDTH-1:0] cur_addr;

  assign hs        = s_valid && s_ready_q;
  assign last_word = (n_q == N_LAST) && (w_q == W_LAST);
  assign cur_addr  = {n_q, w_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      w_q        <= '0;
      lat_q      <= '0;
      cap_q      <= '0;
      s_ready_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_wen_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mm_q       <= '0;
      fev_q      <= 1'b0;
      fea_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      w_q        <= w_d;
      lat_q      <= lat_d;
      cap_q      <= cap_d;
      s_ready_q  <= s_ready_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_wen_q  <= mem_wen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mm_q       <= mm_d;
      fev_q      <= fev_d;
      fea_q      <= fea_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = mode ? S_RD_ISSUE : S_LOAD;
      end
      S_LOAD: begin
        if (hs && last_word) state_d = S_FINISH;
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (lat_q == LAT) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (hs) state_d = last_word ? S_FINISH : S_RD_ISSUE;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    n_d        = n_q;
    w_d        = w_q;
    lat_d      = lat_q;
    cap_d      = cap_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_wen_d  = 1'b0;
    done_d     = 1'b0;
    mm_d       = mm_q;
    fev_d      = fev_q;
    fea_d      = fea_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d   = '0;
          w_d   = '0;
          mm_d  = '0;
          fev_d = 1'b0;
          fea_d = '0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          mem_addr_d = cur_addr;
          mem_din_d  = s_data;
          mem_wen_d  = 1'b1;
        end
      end
      S_RD_ISSUE: begin
        mem_addr_d = cur_addr;
        lat_d      = '0;
      end
      S_RD_WAIT: begin
        // Count 0 is the cycle the address first appears on mem_addr;
        // data is valid READ_LATENCY cycles later and sampled then.
        lat_d = lat_q + 3'd1;
        if (lat_q == LAT) cap_d = mem_dout;
      end
      S_COMPARE: begin
        if (hs && (s_data != cap_q)) begin
          if (mm_q != 16'hFFFF) mm_d = mm_q + 16'd1;
          if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = cur_addr;
          end
        end
      end
      S_FINISH: done_d = 1'b1;
      default: ;
    endcase
    // Shared address walk: weight index first, then neuron index.
    if (hs && !last_word &&
        ((state_q == S_LOAD) || (state_q == S_COMPARE))) begin
      if (w_q == W_LAST) begin
        w_d = '0;
        n_d = n_q + NAW'(1);
      end else begin
        w_d = w_q + WAW'(1);
      end
    end
  end

  assign s_ready_d = (state_d == S_LOAD) || (state_d == S_COMPARE);
  assign busy_d    = (state_d != S_IDLE);

  assign s_ready         = s_ready_q;
  assign mem_addr        = mem_addr_q;
  assign mem_din         = mem_din_q;
  assign mem_wen         = mem_wen_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign mismatch_count  = mm_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;

endmodule

// File: tb/tb_if_layer_weight_loader.sv
// Bench for if_layer_weight_loader: two instances (READ_LATENCY 1 and 3)
// driven in lockstep against layer memory models.
module tb_if_layer_weight_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, mode;
  logic        s_valid  [2];
  logic [31:0] s_data   [2];
  logic        s_ready  [2];
  logic [27:0] mem_addr [2];
  logic [31:0] mem_din  [2];
  logic        mem_wen  [2];
  logic [31:0] mem_dout [2];
  logic        busy     [2];
  logic        done     [2];
  logic [15:0] mism     [2];
  logic        fev      [2];
  logic [27:0] fea      [2];

  int checks   = 0;
  int failures = 0;

  if_layer_weight_loader #(
    .WEIGHT_SIZE(32), .NUM_INPUTS(4), .NUM_NEURONS(2),
    .LAYER_ADDR_WIDTH(28), .WEIGHT_ADDR_WIDTH(10), .READ_LATENCY(1)
  ) u_l1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .s_valid(s_valid[0]), .s_data(s_data[0]), .s_ready(s_ready[0]),
    .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_wen(mem_wen[0]),
    .mem_dout(mem_dout[0]), .busy(busy[0]), .done(done[0]),
    .mismatch_count(mism[0]), .first_err_valid(fev[0]),
    .first_err_addr(fea[0])
  );

  if_layer_weight_loader #(
    .WEIGHT_SIZE(32), .NUM_INPUTS(4), .NUM_NEURONS(2),
    .LAYER_ADDR_WIDTH(28), .WEIGHT_ADDR_WIDTH(10), .READ_LATENCY(3)
  ) u_l3 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .s_valid(s_valid[1]), .s_data(s_data[1]), .s_ready(s_ready[1]),
    .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_wen(mem_wen[1]),
    .mem_dout(mem_dout[1]), .busy(busy[1]), .done(done[1]),
    .mismatch_count(mism[1]), .first_err_valid(fev[1]),
    .first_err_addr(fea[1])
  );

  // Layer memory models: 8 words each, reads delayed by the latency.
  logic [31:0] mem [2][8];
  logic [31:0] p1;
  logic [31:0] p3 [3];

  function automatic int ra(input logic [27:0] a);
    return ((int'(a >> 10) * 4) + int'(a[9:0])) & 7;
  endfunction

  always @(posedge clk) begin
    if (mem_wen[0]) mem[0][ra(mem_addr[0])] <= mem_din[0];
    if (mem_wen[1]) mem[1][ra(mem_addr[1])] <= mem_din[1];
    p1    <= mem[0][ra(mem_addr[0])];
    p3[0] <= mem[1][ra(mem_addr[1])];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign mem_dout[0] = p1;
  assign mem_dout[1] = p3[2];

  logic [31:0] img [3][8];

  function automatic logic [27:0] exp_addr(input int i);
    return 28'(((i / 4) << 10) | (i % 4));
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input bit md, input bit gap, input int sel,
                        input int poke, input bit pre, input int chain,
                        input int rst_after, input int exp_wr,
                        input int exp_mm, input bit exp_fv,
                        input logic [27:0] exp_fa, input string tag);
    int idx [2];
    int wr [2];
    int fwc [2];
    int lwc [2];
    int dc [2];
    bit fin [2];
    bit hs [2];
    bit sawdone;
    for (int d = 0; d < 2; d++) begin
      idx[d] = 0; wr[d] = 0; fwc[d] = 0; lwc[d] = 0;
      dc[d] = 0; fin[d] = 0; hs[d] = 0;
    end
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
      mode  = md;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s[%0d] busy_on_start", tag, d), busy[d], 1);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start = (cyc == poke);
      if (cyc == poke) mode = 1'b1;
      for (int d = 0; d < 2; d++) begin
        s_valid[d] = (idx[d] < 8) && (!gap || (cyc % 2 == 1));
        s_data[d]  = (idx[d] < 8) ? img[sel][idx[d]] : 32'hBAD0_0000;
        hs[d]      = s_valid[d] && s_ready[d];
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) if (hs[d]) idx[d]++;
      #1;
      for (int d = 0; d < 2; d++) begin
        if (mem_wen[d]) begin
          if (wr[d] < 8) begin
            chk($sformatf("%s[%0d] wr%0d_addr", tag, d, wr[d]),
                mem_addr[d], exp_addr(wr[d]));
            chk($sformatf("%s[%0d] wr%0d_data", tag, d, wr[d]),
                mem_din[d], img[sel][wr[d]]);
          end
          if (wr[d] == 0) fwc[d] = cyc;
          lwc[d] = cyc;
          wr[d]++;
        end
        if (done[d]) begin
          if (fin[d]) chk($sformatf("%s[%0d] done_twice", tag, d), done[d], 0);
          else begin
            fin[d] = 1;
            dc[d]  = cyc;
            chk($sformatf("%s[%0d] busy_at_done", tag, d), busy[d], 0);
          end
        end
      end
      if (rst_after > 0 && wr[0] == rst_after) begin
        @(negedge clk);
        rst = 1'b0;
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("%s[%0d] rst_wen", tag, d), mem_wen[d], 0);
          chk($sformatf("%s[%0d] rst_ready", tag, d), s_ready[d], 0);
          chk($sformatf("%s[%0d] rst_busy", tag, d), busy[d], 0);
        end
        @(negedge clk);
        rst = 1'b1;
        sawdone = 0;
        repeat (5) begin
          @(posedge clk); #1;
          if (done[0] || done[1]) sawdone = 1;
        end
        chk($sformatf("%s no_done_after_rst", tag), sawdone, 0);
        return;
      end
      if (fin[0] && fin[1]) break;
    end
    s_valid[0] = 1'b0;
    s_valid[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s[%0d] done_seen", tag, d), fin[d], 1);
      chk($sformatf("%s[%0d] writes", tag, d), wr[d], exp_wr);
      chk($sformatf("%s[%0d] consumed", tag, d), idx[d], 8);
      chk($sformatf("%s[%0d] mismatch", tag, d), mism[d], exp_mm);
      chk($sformatf("%s[%0d] first_valid", tag, d), fev[d], exp_fv);
      chk($sformatf("%s[%0d] first_addr", tag, d), fea[d], exp_fa);
      if (md == 0) begin
        chk($sformatf("%s[%0d] done_lag", tag, d), dc[d] - lwc[d], 1);
        if (!gap)
          chk($sformatf("%s[%0d] wen_span", tag, d), lwc[d] - fwc[d], 7);
      end
    end
    if (chain >= 0) begin
      @(negedge clk);
      start = 1'b1;
      mode  = (chain == 1);
    end else begin
      repeat (2) begin @(posedge clk); #1; end
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("%s[%0d] hold_mm", tag, d), mism[d], exp_mm);
        chk($sformatf("%s[%0d] hold_fa", tag, d), fea[d], exp_fa);
      end
    end
  endtask

  typedef struct {
    bit          md;
    bit          gap;
    int          sel;
    int          exp_wr;
    int          exp_mm;
    bit          exp_fv;
    logic [27:0] exp_fa;
  } vec_t;

  vec_t tv [7];

  initial begin
    for (int i = 0; i < 8; i++) begin
      img[0][i] = 32'h10 + 32'(i);
      img[1][i] = 32'h10 + 32'(i);
      img[2][i] = 32'hA0 + 32'(i);
    end
    img[1][5] = 32'hDEAD;
    img[1][7] = 32'hBEEF;

    tv[0] = '{0, 0, 0, 8, 0, 0, 28'h000};
    tv[1] = '{1, 0, 0, 0, 0, 0, 28'h000};
    tv[2] = '{1, 1, 1, 0, 2, 1, 28'h401};
    tv[3] = '{0, 1, 2, 8, 0, 0, 28'h000};
    tv[4] = '{1, 0, 0, 0, 8, 1, 28'h000};
    tv[5] = '{0, 1, 0, 8, 0, 0, 28'h000};
    tv[6] = '{1, 1, 0, 0, 0, 0, 28'h000};

    rst = 1'b0; start = 1'b0; mode = 1'b0;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0;
      s_data[d]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset[%0d] s_ready", d), s_ready[d], 0);
      chk($sformatf("reset[%0d] mem_wen", d), mem_wen[d], 0);
      chk($sformatf("reset[%0d] mem_addr", d), mem_addr[d], 0);
      chk($sformatf("reset[%0d] mem_din", d), mem_din[d], 0);
      chk($sformatf("reset[%0d] busy", d), busy[d], 0);
      chk($sformatf("reset[%0d] done", d), done[d], 0);
      chk($sformatf("reset[%0d] mismatch", d), mism[d], 0);
      chk($sformatf("reset[%0d] first_valid", d), fev[d], 0);
      chk($sformatf("reset[%0d] first_addr", d), fea[d], 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_op(tv[i].md, tv[i].gap, tv[i].sel, -1, 0, -1, 0,
             tv[i].exp_wr, tv[i].exp_mm, tv[i].exp_fv, tv[i].exp_fa,
             $sformatf("vec%0d", i));

    // start during LOAD is ignored; start in the done cycle chains VERIFY
    run_op(0, 0, 1, 3, 0, 1, 0, 8, 0, 0, 28'h000, "poke_load");
    run_op(1, 0, 1, -1, 1, -1, 0, 0, 0, 0, 28'h000, "chain_verify");

    // reset after three writes aborts, next LOAD restarts at 0x000
    run_op(0, 0, 2, -1, 0, -1, 3, 0, 0, 0, 28'h000, "rst_mid");
    run_op(0, 0, 0, -1, 0, -1, 0, 8, 0, 0, 28'h000, "reload");
    run_op(1, 0, 0, -1, 0, -1, 0, 0, 0, 0, 28'h000, "reverify");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_layer_weight_loader.md
Name: if_layer_weight_loader

Overview:
Bus-side initiator for the spiking layer's weight-memory port. It drives the layer's mem_addr, mem_din and mem_wen, and reads mem_dout back.
- LOAD mode: streams a neuron-major weight image from a valid/ready source into every neuron's weight memory.
- VERIFY mode: reads each weight back and compares it against the same image, streamed again, and counts mismatches.
Sits between the host/DMA weight source and the layer, so weights can be programmed and checked without per-word host accesses.

Parameters:
WEIGHT_SIZE, 32, width of one weight word
NUM_INPUTS, 4, weights per neuron; must be <= 2**WEIGHT_ADDR_WIDTH
NUM_NEURONS, 1, neurons in target layer; must be <= 2**(LAYER_ADDR_WIDTH-WEIGHT_ADDR_WIDTH)
LAYER_ADDR_WIDTH, 28, width of layer memory address
WEIGHT_ADDR_WIDTH, 10, low address bits indexing a weight within a neuron
READ_LATENCY, 1, cycles from mem_addr presented to mem_dout valid; range 1..7

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
start  in  1  one-cycle pulse; begins an operation when idle
mode  in  1  sampled with start: 0 = LOAD, 1 = VERIFY
s_valid  in  1  weight stream valid
s_data  in  WEIGHT_SIZE  weight word, neuron-major order
s_ready  out  1  weight stream ready
mem_addr  out  LAYER_ADDR_WIDTH  to layer: {neuron index, weight index}
mem_din  out  WEIGHT_SIZE  to layer write data
mem_wen  out  1  to layer write enable
mem_dout  in  WEIGHT_SIZE  from layer read data
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
mismatch_count  out  16  VERIFY mismatches; saturates at 0xFFFF
first_err_valid  out  1  at least one mismatch seen
first_err_addr  out  LAYER_ADDR_WIDTH  mem_addr of first mismatch

Behaviour:
- Reset (rst=0 at a clk edge):
  - state returns to IDLE; all counters are cleared.
  - s_ready=0, mem_wen=0, mem_addr=0, mem_din=0, busy=0, done=0, mismatch_count=0, first_err_valid=0, first_err_addr=0.
  - Reset mid-operation aborts immediately. A write already registered is not completed, and no done pulse is issued.
- Address formation:
  - mem_addr = (n << WEIGHT_ADDR_WIDTH) | w, zero-extended; n = neuron index, w = weight index.
  - Sequence: w increments 0..NUM_INPUTS-1, then wraps to 0 and n increments. The last word is n=NUM_NEURONS-1, w=NUM_INPUTS-1.
  - Total words = NUM_NEURONS*NUM_INPUTS.
- All outputs are registered.
- States: IDLE, LOAD, RD_ISSUE, RD_WAIT, COMPARE, FINISH.
- IDLE:
  - start=1 with mode=0 -> LOAD.
  - start=1 with mode=1 -> RD_ISSUE.
  - On either transition: clear n, w, mismatch_count, first_err_valid and first_err_addr.
  - start is ignored in every other state.
- LOAD:
  - s_ready=1. Each s_valid&&s_ready handshake registers mem_addr=current address, mem_din=s_data and mem_wen=1 for exactly the next cycle.
  - Throughput is one write per cycle; back-to-back handshakes give consecutive mem_wen cycles. With no handshake, mem_wen=0 the next cycle.
  - On the handshake of the last word: s_ready drops the next cycle, and the state goes to FINISH. The final mem_wen is high in the first FINISH cycle.
- RD_ISSUE:
  - Registers mem_addr=current address, mem_wen=0, then goes to RD_WAIT.
- RD_WAIT:
  - Counts READ_LATENCY cycles after mem_addr is presented.
  - On the terminal count, captures mem_dout into an internal register and goes to COMPARE.
- COMPARE:
  - s_ready=1 until an s_valid handshake.
  - On the handshake, if s_data != captured word: mismatch_count increments (saturating). If first_err_valid=0, it sets first_err_valid=1 and first_err_addr=the address being compared.
  - After the handshake: last word -> FINISH, else advance n/w -> RD_ISSUE.
  - mem_wen is never asserted in VERIFY.
- FINISH:
  - Lasts one cycle; mem_wen follows its registered value (last LOAD write).
  - The next cycle: done=1 for one cycle, busy=0, state IDLE. A start in that same cycle is accepted.
- Result holding: mismatch_count, first_err_valid and first_err_addr hold after done until the next accepted start or reset.
- s_data is never consumed outside LOAD/COMPARE handshakes; extra stream words stay pending.

Test Plan:
- NUM_NEURONS=2, NUM_INPUTS=4, WEIGHT_ADDR_WIDTH=10; LOAD with continuous s_valid, data 0x10..0x17 -> 8 consecutive mem_wen cycles at addrs 0x000-0x003, 0x400-0x403 with matching data; done one cycle after FINISH; busy low afterward.
- Same LOAD with s_valid deasserted every other cycle -> mem_wen only after handshakes, same address/data sequence, no duplicate or skipped addresses.
- VERIFY against a layer model loaded as above, READ_LATENCY=1 and =3 -> no mem_wen, each address held READ_LATENCY cycles before compare, mismatch_count=0, first_err_valid=0.
- VERIFY with expected word 5 changed to 0xDEAD and word 7 changed -> mismatch_count=2, first_err_valid=1, first_err_addr=0x401.
- start pulsed mid-LOAD with mode=1 -> ignored, LOAD completes normally; start in the done cycle -> new operation begins next cycle.
- rst=0 after 3 LOAD writes -> next cycle mem_wen=0, s_ready=0, busy=0, no done; a subsequent LOAD restarts at address 0x000.
